// File: rtl/alu_ctrl_fsm_pkg.sv
// alu_ctrl_fsm_pkg: shared opcodes, aluSel codes, instruction field positions and FSM states.
package alu_ctrl_fsm_pkg;
  localparam int OPC_LO = 27;
  localparam int I_BIT = 26;
  localparam int RD_LO = 22;
  localparam int RS1_LO = 18;
  localparam int RS2_LO = 14;
  localparam int N_OPS = 13;
  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_SUB = 5'd1;
  localparam logic [4:0] OP_MUL = 5'd2;
  localparam logic [4:0] OP_DIV = 5'd3;
  localparam logic [4:0] OP_MOD = 5'd4;
  localparam logic [4:0] OP_CMP = 5'd5;
  localparam logic [4:0] OP_AND = 5'd6;
  localparam logic [4:0] OP_OR = 5'd7;
  localparam logic [4:0] OP_NOT = 5'd8;
  localparam logic [4:0] OP_MOV = 5'd9;
  localparam logic [4:0] OP_LSL = 5'd10;
  localparam logic [4:0] OP_LSR = 5'd11;
  localparam logic [4:0] OP_ASR = 5'd12;
  localparam logic [4:0] OP_NOP = 5'd13;
  localparam logic [2:0] SEL_ADD = 3'd0;
  localparam logic [2:0] SEL_MUL = 3'd1;
  localparam logic [2:0] SEL_DIV = 3'd2;
  localparam logic [2:0] SEL_MOV = 3'd3;
  localparam logic [2:0] SEL_LOGIC = 3'd4;
  localparam logic [2:0] SEL_SHIFT = 3'd5;
  typedef enum logic [2:0] {S_CLR, S_IDLE, S_DECODE, S_EXECUTE, S_FLAG, S_WB} state_t;
endpackage

// File: rtl/alu_ctrl_fsm_if.sv
// alu_ctrl_fsm_if: fetch handshake, ALU control strobes and writeback handshake.
// master: upstream/writeback side (drives instr_valid, instr, wb_ready); slave: the control stage.
interface alu_ctrl_fsm_if;
  logic instr_valid, instr_ready;
  logic [31:0] instr;
  logic [3:0] rs1_addr, rs2_addr;
  logic [31:0] imm;
  logic isImmediate;
  logic isAdd, isSub, isCmp, isMul, isDiv, isMod, isLsl, isLsr, isAsr, isOr, isNot, isAnd, isMov;
  logic [2:0] aluSel;
  logic ldResult, clrResult;
  logic wb_valid, wb_ready;
  logic [3:0] wb_rd;
  logic flag_wr, illegal, busy;
  modport master (
    output instr_valid, instr, wb_ready,
    input instr_ready, rs1_addr, rs2_addr, imm, isImmediate,
    isAdd, isSub, isCmp, isMul, isDiv, isMod, isLsl, isLsr, isAsr, isOr, isNot, isAnd, isMov,
    aluSel, ldResult, clrResult, wb_valid, wb_rd, flag_wr, illegal, busy
  );
  modport slave (
    input instr_valid, instr, wb_ready,
    output instr_ready, rs1_addr, rs2_addr, imm, isImmediate,
    isAdd, isSub, isCmp, isMul, isDiv, isMod, isLsl, isLsr, isAsr, isOr, isNot, isAnd, isMov,
    aluSel, ldResult, clrResult, wb_valid, wb_rd, flag_wr, illegal, busy
  );
endinterface

// File: rtl/alu_ctrl_fsm_op_decode.sv
// alu_ctrl_fsm_op_decode: combinational opcode -> op one-hot (bit index = opcode), aluSel, legal, nop.
// Ports: op in; ops/sel/legal/nop out. nop and illegal opcodes yield no strobes and aluSel 0.
module alu_ctrl_fsm_op_decode
  import alu_ctrl_fsm_pkg::*;
(
  input  logic [4:0]       op,
  output logic [N_OPS-1:0] ops,
  output logic [2:0]       sel,
  output logic             legal,
  output logic             nop
);
  always_comb begin
    legal = op <= OP_NOP;
    nop = op == OP_NOP;
    ops = op < OP_NOP ? N_OPS'(1) << op : '0;
    sel = op == OP_MUL ? SEL_MUL :
          (op == OP_DIV || op == OP_MOD) ? SEL_DIV :
          op == OP_MOV ? SEL_MOV :
          (op inside {OP_AND, OP_OR, OP_NOT}) ? SEL_LOGIC :
          (op inside {OP_LSL, OP_LSR, OP_ASR}) ? SEL_SHIFT : SEL_ADD;
  end
endmodule

// File: rtl/alu_ctrl_fsm.sv
// alu_ctrl_fsm: decode/sequencing stage ahead of the ALU, one instruction in flight.
// Ports: clk, rst_n (async active-low), bus (alu_ctrl_fsm_if.slave: fetch handshake,
// register addresses, immediate, op strobes, result load/clear, writeback handshake, status).
module alu_ctrl_fsm
  import alu_ctrl_fsm_pkg::*;
#(
  parameter int DIV_CYCLES = 4,
  parameter int IMM_W = 18
) (
  input logic clk,
  input logic rst_n,
  alu_ctrl_fsm_if.slave bus
);
  localparam int CW = $clog2(DIV_CYCLES) + 1;
  state_t state;
  logic [4:0] op_q;
  logic [CW-1:0] cnt;
  logic [N_OPS-1:0] ops_q, dec_ops;
  logic [2:0] dec_sel;
  logic dec_legal, dec_nop, divmod;
  alu_ctrl_fsm_op_decode u_dec (.op(op_q), .ops(dec_ops), .sel(dec_sel), .legal(dec_legal), .nop(dec_nop));
  assign divmod = op_q == OP_DIV || op_q == OP_MOD;
  assign bus.isAdd = ops_q[OP_ADD];
  assign bus.isSub = ops_q[OP_SUB];
  assign bus.isMul = ops_q[OP_MUL];
  assign bus.isDiv = ops_q[OP_DIV];
  assign bus.isMod = ops_q[OP_MOD];
  assign bus.isCmp = ops_q[OP_CMP];
  assign bus.isAnd = ops_q[OP_AND];
  assign bus.isOr = ops_q[OP_OR];
  assign bus.isNot = ops_q[OP_NOT];
  assign bus.isMov = ops_q[OP_MOV];
  assign bus.isLsl = ops_q[OP_LSL];
  assign bus.isLsr = ops_q[OP_LSR];
  assign bus.isAsr = ops_q[OP_ASR];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_CLR;
      op_q <= '0;
      cnt <= '0;
      ops_q <= '0;
      bus.instr_ready <= 1'b0;
      bus.rs1_addr <= '0;
      bus.rs2_addr <= '0;
      bus.imm <= '0;
      bus.isImmediate <= 1'b0;
      bus.aluSel <= '0;
      bus.ldResult <= 1'b0;
      bus.clrResult <= 1'b0;
      bus.wb_valid <= 1'b0;
      bus.wb_rd <= '0;
      bus.flag_wr <= 1'b0;
      bus.illegal <= 1'b0;
      bus.busy <= 1'b0;
    end else begin
      bus.ldResult <= 1'b0;
      bus.clrResult <= 1'b0;
      bus.illegal <= 1'b0;
      bus.flag_wr <= 1'b0;
      case (state)
        // clrResult doubles as the first/second-cycle marker so the clear pulse precedes instr_ready
        S_CLR: begin
          if (!bus.clrResult) begin
            bus.clrResult <= 1'b1;
            bus.busy <= 1'b1;
          end else begin
            state <= S_IDLE;
            bus.instr_ready <= 1'b1;
            bus.busy <= 1'b0;
          end
        end
        S_IDLE: begin
          if (bus.instr_valid) begin
            state <= S_DECODE;
            bus.instr_ready <= 1'b0;
            bus.busy <= 1'b1;
            op_q <= bus.instr[OPC_LO +: 5];
            bus.isImmediate <= bus.instr[I_BIT];
            bus.rs1_addr <= bus.instr[RS1_LO +: 4];
            bus.rs2_addr <= bus.instr[RS2_LO +: 4];
            bus.wb_rd <= bus.instr[RD_LO +: 4];
            bus.imm <= {{(32-IMM_W){bus.instr[IMM_W-1]}}, bus.instr[IMM_W-1:0]};
          end
        end
        S_DECODE: begin
          ops_q <= dec_ops;
          bus.aluSel <= dec_sel;
          if (!dec_legal || dec_nop) begin
            state <= S_IDLE;
            bus.instr_ready <= 1'b1;
            bus.busy <= 1'b0;
            bus.illegal <= !dec_legal;
            bus.clrResult <= !dec_legal;
          end else begin
            state <= S_EXECUTE;
            cnt <= divmod ? CW'(DIV_CYCLES - 1) : '0;
            bus.ldResult <= !divmod || DIV_CYCLES == 1;
          end
        end
        S_EXECUTE: begin
          if (cnt == '0) begin
            ops_q <= '0;
            bus.aluSel <= '0;
            state <= ops_q[OP_CMP] ? S_FLAG : S_WB;
            bus.flag_wr <= ops_q[OP_CMP];
            bus.wb_valid <= !ops_q[OP_CMP];
          end else begin
            cnt <= cnt - CW'(1);
            bus.ldResult <= cnt == CW'(1);
          end
        end
        S_FLAG: begin
          state <= S_IDLE;
          bus.instr_ready <= 1'b1;
          bus.busy <= 1'b0;
        end
        S_WB: begin
          if (bus.wb_ready) begin
            state <= S_IDLE;
            bus.wb_valid <= 1'b0;
            bus.instr_ready <= 1'b1;
            bus.busy <= 1'b0;
          end
        end
        default: state <= S_CLR;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// tb_alu_ctrl_fsm: directed + random instruction stream checked cycle by cycle against a timeline model.
module tb_alu_ctrl_fsm;
  localparam int DIV = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  int sel_tab [14] = '{0, 0, 1, 2, 2, 0, 4, 4, 4, 3, 5, 5, 5, 0};
  logic [12:0] ops;
  logic [67:0] outs;
  always #5 clk = ~clk;
  alu_ctrl_fsm_if b();
  alu_ctrl_fsm #(.DIV_CYCLES(DIV), .IMM_W(18)) dut (.clk(clk), .rst_n(rst_n), .bus(b));
  assign ops = {b.isAsr, b.isLsr, b.isLsl, b.isMov, b.isNot, b.isOr, b.isAnd,
                b.isCmp, b.isMod, b.isDiv, b.isMul, b.isSub, b.isAdd};
  assign outs = {b.instr_ready, b.rs1_addr, b.rs2_addr, b.imm, b.isImmediate, ops, b.aluSel,
                 b.ldResult, b.clrResult, b.wb_valid, b.wb_rd, b.flag_wr, b.illegal, b.busy};

  task automatic chk(input string tag, input logic [67:0] o, input logic [67:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic do_reset();
    b.instr_valid = 1'b0;
    b.wb_ready = 1'b0;
    rst_n = 1'b0;
    #2;
    chk("reset_outs_zero", outs, 68'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("clr_pulse", b.clrResult, 1);
    chk("clr_not_ready", b.instr_ready, 0);
    chk("clr_busy", b.busy, 1);
    @(negedge clk);
    chk("idle_after_clr", outs, 68'd1 << 67);
  endtask

  task automatic run(input logic [31:0] ins, input int stall);
    logic [4:0] op;
    int n;
    op = ins[31:27];
    chk("idle_ready", b.instr_ready, 1);
    b.instr_valid = 1'b1;
    b.instr = ins;
    @(negedge clk);
    b.instr_valid = 1'($urandom_range(0, 1));
    b.instr = $urandom;
    chk("dec_ready", b.instr_ready, 0);
    chk("dec_busy", b.busy, 1);
    chk("dec_rs1", b.rs1_addr, ins[21:18]);
    if (!ins[26]) chk("dec_rs2", b.rs2_addr, ins[17:14]);
    chk("dec_imm", b.imm, {{14{ins[17]}}, ins[17:0]});
    chk("dec_isimm", b.isImmediate, ins[26]);
    if (op > 5'd13) begin
      @(negedge clk);
      b.instr_valid = 1'b0;
      chk("ill_pulse", b.illegal, 1);
      chk("ill_clr", b.clrResult, 1);
      chk("ill_no_ld", b.ldResult, 0);
      chk("ill_no_ops", ops, 0);
      chk("ill_ready", b.instr_ready, 1);
      @(negedge clk);
      chk("ill_pulse_end", {b.illegal, b.clrResult}, 0);
      chk("ill_idle", b.instr_ready, 1);
    end else if (op == 5'd13) begin
      @(negedge clk);
      b.instr_valid = 1'b0;
      chk("nop_no_strobes", {ops, b.aluSel, b.ldResult, b.illegal, b.wb_valid, b.flag_wr}, 0);
      chk("nop_ready", b.instr_ready, 1);
    end else begin
      n = (op == 5'd3 || op == 5'd4) ? DIV : 1;
      for (int k = 0; k < n; k++) begin
        @(negedge clk);
        b.instr_valid = 1'($urandom_range(0, 1));
        chk("ex_onehot", ops, 13'(1) << op);
        chk("ex_alusel", b.aluSel, sel_tab[op]);
        chk("ex_ld", b.ldResult, k == n - 1);
        chk("ex_no_wb", {b.wb_valid, b.flag_wr, b.instr_ready}, 0);
        chk("ex_isimm", b.isImmediate, ins[26]);
      end
      @(negedge clk);
      if (op == 5'd5) begin
        chk("flag_wr", b.flag_wr, 1);
        chk("flag_no_wb", b.wb_valid, 0);
        chk("flag_ops_drop", {ops, b.aluSel, b.ldResult}, 0);
        chk("flag_not_ready", b.instr_ready, 0);
        @(negedge clk);
        b.instr_valid = 1'b0;
        chk("flag_end", {b.flag_wr, b.wb_valid}, 0);
        chk("flag_ready", b.instr_ready, 1);
      end else begin
        for (int i = 0; i <= stall; i++) begin
          if (i > 0) @(negedge clk);
          b.instr_valid = 1'($urandom_range(0, 1));
          chk("wb_valid", b.wb_valid, 1);
          chk("wb_rd", b.wb_rd, ins[25:22]);
          chk("wb_ops_drop", {ops, b.aluSel, b.ldResult}, 0);
          chk("wb_not_ready", b.instr_ready, 0);
        end
        b.wb_ready = 1'b1;
        @(negedge clk);
        b.wb_ready = 1'b0;
        b.instr_valid = 1'b0;
        chk("wb_done", b.wb_valid, 0);
        chk("wb_ready_idle", {b.instr_ready, b.busy}, 2'b10);
      end
    end
  endtask

  initial begin
    logic [31:0] ins;
    b.instr = '0;
    b.instr_valid = 1'b0;
    b.wb_ready = 1'b0;
    @(negedge clk);
    do_reset();
    run(32'h00C48000, 0);
    run(32'h1D440007, 0);
    run(32'h28048000, 0);
    run(32'hA0000000, 0);
    run(32'h68000000, 0);
    run(32'h00C48000, 5);
    run(32'h0CA7FFFF, 1);
    for (int t = 0; t < 60; t++) begin
      ins = $urandom;
      ins[31:27] = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(14, 31)) : 5'($urandom_range(0, 13));
      run(ins, $urandom_range(0, 3));
    end
    b.instr_valid = 1'b1;
    b.instr = 32'h1D440007;
    @(negedge clk);
    b.instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("div_in_exec", ops, 13'h0008);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outs", outs, 68'd0);
    do_reset();
    run(32'h00C48000, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end
endmodule
